// File: rtl/loop_drv_pkg.sv
// Shared types and constants for the loop driver dead-time controller.
//   loop_dt_state_t : controller state encoding
//   FC_NONE/FC_TMO/FC_SHOOT : values reported on fault_code
package loop_drv_pkg;

    typedef enum logic [2:0] {
        OFF,
        WAIT_OFF,
        DEAD,
        TOP_ON,
        BOT_ON,
        FAULT
    } loop_dt_state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_TMO   = 2'b01;
    localparam logic [1:0] FC_SHOOT = 2'b10;

endpackage

// File: rtl/loop_fb_sync.sv
// Two-flop synchronizer for one asynchronous gate-feedback bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output, 2 cycles of latency
module loop_fb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/loop_deadtime_ctrl.sv
// Break-before-make controller for the loop driver's top/bottom gate pair.
// Turns the pwm request into non-overlapping gate enables, waiting for the
// sensed gate feedback to show both gates off plus a configurable dead time
// before turning the opposite gate on. Latches a fault on a gate-off timeout
// or when both gates are sensed on together.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : run request, 0 forces both enables off
//   pwm        : 1 requests top on, 0 requests bottom on
//   dt_cfg     : dead time in cycles (0 behaves as 1), sampled on DEAD entry
//   top_fb     : sensed top gate state (asynchronous)
//   bot_fb     : sensed bottom gate state (asynchronous)
//   fault_clr  : pulse that clears a latched fault
//   top_en     : top gate enable (registered)
//   bot_en     : bottom gate enable (registered)
//   fault      : fault latched
//   fault_code : 00 none, 01 timeout, 10 shoot-through
//   sw_cnt     : count of TOP_ON/BOT_ON entries, wrapping
module loop_deadtime_ctrl
    import loop_drv_pkg::*;
#(
    parameter int unsigned DT_W  = 6,
    parameter int unsigned TMO   = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm,
    input  logic [DT_W-1:0]  dt_cfg,
    input  logic             top_fb,
    input  logic             bot_fb,
    input  logic             fault_clr,
    output logic             top_en,
    output logic             bot_en,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] sw_cnt
);

    localparam int unsigned TMO_W = $clog2(TMO + 1);

    loop_dt_state_t   state;
    logic             top_fb_s;
    logic             bot_fb_s;
    logic             shoot;
    logic [TMO_W-1:0] tmo_cnt;
    logic [DT_W-1:0]  dead_cnt;
    logic [DT_W-1:0]  dead_load;

    loop_fb_sync u_top_sync (
        .clk (clk),
        .rst (rst),
        .d   (top_fb),
        .q   (top_fb_s)
    );

    loop_fb_sync u_bot_sync (
        .clk (clk),
        .rst (rst),
        .d   (bot_fb),
        .q   (bot_fb_s)
    );

    always_comb begin
        shoot     = top_fb_s & bot_fb_s;
        dead_load = (dt_cfg == '0) ? DT_W'(1) : dt_cfg;
    end

    // Enables/fault default low each cycle and are re-asserted only by the
    // branch that lands in (or stays in) their state, so they always match
    // the registered state without a separate decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            top_en     <= 1'b0;
            bot_en     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            sw_cnt     <= '0;
            tmo_cnt    <= '0;
            dead_cnt   <= '0;
        end else begin
            top_en <= 1'b0;
            bot_en <= 1'b0;
            fault  <= 1'b0;
            if (state != FAULT && shoot) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_code <= FC_SHOOT;
            end else if (state != FAULT && !enable) begin
                state <= OFF;
            end else begin
                case (state)
                    OFF: begin
                        if (enable) begin
                            state   <= WAIT_OFF;
                            tmo_cnt <= '0;
                        end
                    end
                    WAIT_OFF: begin
                        if (!top_fb_s && !bot_fb_s) begin
                            state    <= DEAD;
                            dead_cnt <= dead_load;
                        end else if (tmo_cnt == TMO_W'(TMO)) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= FC_TMO;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    DEAD: begin
                        if (dead_cnt == DT_W'(1)) begin
                            if (pwm) begin
                                state  <= TOP_ON;
                                top_en <= 1'b1;
                            end else begin
                                state  <= BOT_ON;
                                bot_en <= 1'b1;
                            end
                            sw_cnt <= sw_cnt + CNT_W'(1);
                        end else begin
                            dead_cnt <= dead_cnt - DT_W'(1);
                        end
                    end
                    TOP_ON: begin
                        if (!pwm) begin
                            state   <= WAIT_OFF;
                            tmo_cnt <= '0;
                        end else begin
                            top_en <= 1'b1;
                        end
                    end
                    BOT_ON: begin
                        if (pwm) begin
                            state   <= WAIT_OFF;
                            tmo_cnt <= '0;
                        end else begin
                            bot_en <= 1'b1;
                        end
                    end
                    FAULT: begin
                        // A live shoot-through condition blocks the clear.
                        if (fault_clr && !shoot) begin
                            state      <= OFF;
                            fault_code <= FC_NONE;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loop_deadtime_ctrl.sv
module tb_loop_deadtime_ctrl;

    localparam int DT_W  = 6;
    localparam int TMO   = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             pwm = 1'b0;
    logic [DT_W-1:0]  dt_cfg = '0;
    logic             top_fb = 1'b0;
    logic             bot_fb = 1'b0;
    logic             fault_clr = 1'b0;
    logic             top_en;
    logic             bot_en;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] sw_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    loop_deadtime_ctrl #(.DT_W(DT_W), .TMO(TMO), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pwm        (pwm),
        .dt_cfg     (dt_cfg),
        .top_fb     (top_fb),
        .bot_fb     (bot_fb),
        .fault_clr  (fault_clr),
        .top_en     (top_en),
        .bot_en     (bot_en),
        .fault      (fault),
        .fault_code (fault_code),
        .sw_cnt     (sw_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (event/timestamp based) ----------------
    typedef enum int {M_OFF, M_WAIT, M_DEAD, M_TOP, M_BOT, M_FAULT} mode_t;
    mode_t m_mode = M_OFF;
    int    cyc = 0, wait_start = 0, dead_exit = 0, m_code = 0, m_cnt = 0, m_dt = 1;
    bit    tq[$];
    bit    bq[$];
    bit    m_st, m_sb, m_both;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = M_OFF;
            m_code = 0;
            m_cnt  = 0;
            cyc    = 0;
            tq.delete();
            bq.delete();
        end else begin
            cyc++;
            // feedback seen by the decision logic is the pin value two edges back
            m_st   = (tq.size() >= 2) ? tq[tq.size()-2] : 1'b0;
            m_sb   = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
            m_both = m_st && m_sb;
            m_dt   = (dt_cfg == 0) ? 1 : int'(dt_cfg);
            if (m_mode != M_FAULT && m_both) begin
                m_mode = M_FAULT;
                m_code = 2;
            end else if (m_mode != M_FAULT && !enable) begin
                m_mode = M_OFF;
            end else begin
                case (m_mode)
                    M_OFF:   if (enable) begin m_mode = M_WAIT; wait_start = cyc; end
                    M_WAIT:  if (!m_st && !m_sb) begin
                                 m_mode = M_DEAD;
                                 dead_exit = cyc + m_dt;
                             end else if (cyc - wait_start > TMO) begin
                                 m_mode = M_FAULT;
                                 m_code = 1;
                             end
                    M_DEAD:  if (cyc == dead_exit) begin
                                 m_mode = pwm ? M_TOP : M_BOT;
                                 m_cnt++;
                             end
                    M_TOP:   if (!pwm) begin m_mode = M_WAIT; wait_start = cyc; end
                    M_BOT:   if (pwm) begin m_mode = M_WAIT; wait_start = cyc; end
                    default: if (fault_clr && !m_both) begin m_mode = M_OFF; m_code = 0; end
                endcase
            end
            tq.push_back(top_fb);
            bq.push_back(bot_fb);
            if (tq.size() > 4) begin
                void'(tq.pop_front());
                void'(bq.pop_front());
            end
        end
    end

    logic [CNT_W-1:0] m_cnt_w;
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            m_cnt_w = CNT_W'(m_cnt);
            chk("model", 32'({top_en, bot_en, fault, fault_code, sw_cnt}),
                32'({m_mode == M_TOP, m_mode == M_BOT, m_mode == M_FAULT, 2'(m_code), m_cnt_w}));
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic en, pw;
        int   dt;
        logic tfb, bfb, clr;
        logic top, bot, flt;
        int   code, cnt;
    } vec_t;
    vec_t vq[$];

    task automatic row(input logic en, input logic pw, input int dt, input logic tfb,
                       input logic bfb, input logic clr, input logic top, input logic bot,
                       input logic flt, input int code, input int cnt);
        vec_t v;
        v.en = en; v.pw = pw; v.dt = dt; v.tfb = tfb; v.bfb = bfb; v.clr = clr;
        v.top = top; v.bot = bot; v.flt = flt; v.code = code; v.cnt = cnt;
        vq.push_back(v);
    endtask

    int  n, exp_cnt, stuck;
    bit  saw_wrap, tgt;
    logic [CNT_W-1:0] prev_cnt;

    initial begin
        //   en pw dt tfb bfb clr | top bot flt code cnt
        row(1, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0);   // -> WAIT_OFF
        for (int i = 0; i < 4; i++)
            row(1, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0); // DEAD x4
        row(1, 0, 4, 0, 0, 0,  0, 1, 0, 0, 1);   // BOT_ON, 5 after WAIT_OFF entry
        row(1, 0, 4, 0, 1, 0,  0, 1, 0, 0, 1);
        row(1, 0, 4, 0, 1, 0,  0, 1, 0, 0, 1);
        row(1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1);   // pwm up: bot_en drops +1
        row(1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        row(1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        row(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);   // bot_fb falls
        row(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        row(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        row(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2);   // top_en 1+2+1 after fall
        row(1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 2);
        row(1, 1, 0, 1, 1, 0,  1, 0, 0, 0, 2);   // both feedbacks high
        row(1, 1, 0, 1, 1, 0,  1, 0, 0, 0, 2);
        row(1, 1, 0, 1, 1, 0,  0, 0, 1, 2, 2);   // shoot-through fault
        row(0, 1, 0, 0, 0, 0,  0, 0, 1, 2, 2);   // enable ignored in fault
        row(1, 1, 0, 0, 0, 0,  0, 0, 1, 2, 2);
        row(1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 2);   // clear -> OFF
        row(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2);
        row(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2);
        row(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3);
        row(1, 1, 0, 1, 1, 0,  1, 0, 0, 0, 3);
        row(1, 1, 0, 1, 1, 0,  1, 0, 0, 0, 3);
        row(1, 1, 0, 1, 1, 1,  0, 0, 1, 2, 3);   // clr outside fault has no effect
        row(1, 1, 0, 0, 0, 1,  0, 0, 1, 2, 3);   // clr blocked by live shoot-through
        row(1, 1, 0, 0, 0, 0,  0, 0, 1, 2, 3);
        row(1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 3);
        row(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_top_en", 32'(top_en), 0);
        chk("rst_bot_en", 32'(bot_en), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);
        chk("rst_cnt", 32'(sw_cnt), 0);
        chk_on = 1'b1;
        rst = 1'b0;

        foreach (vq[i]) begin
            enable = vq[i].en; pwm = vq[i].pw; dt_cfg = DT_W'(vq[i].dt);
            top_fb = vq[i].tfb; bot_fb = vq[i].bfb; fault_clr = vq[i].clr;
            tick();
            chk($sformatf("vec%0d", i),
                32'({top_en, bot_en, fault, fault_code, sw_cnt}),
                32'({vq[i].top, vq[i].bot, vq[i].flt, 2'(vq[i].code), CNT_W'(vq[i].cnt)}));
        end

        // timeout: top_fb stuck high while waiting for gates off
        fault_clr = 1'b0; pwm = 1'b1; dt_cfg = 3; top_fb = 1'b1;
        tick(); tick();
        enable = 1'b1;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            tick();
            chk($sformatf("tmo_hold%0d", k), 32'(fault), 0);
        end
        tick();
        chk("tmo_fault", 32'({fault, fault_code}), 32'({1'b1, 2'b01}));
        fault_clr = 1'b1;
        tick();
        chk("tmo_clear", 32'({fault, fault_code}), 0);
        fault_clr = 1'b0; top_fb = 1'b0;
        n = 0;
        while (!top_en && n < 20) begin tick(); n++; end
        chk("clr_to_top_cycles", 32'(n), 6);

        // enable dropped in the middle of the dead time
        pwm = 1'b0; dt_cfg = 10;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        chk("dead_abort_en", 32'({top_en, bot_en}), 0);
        repeat (12) tick();
        chk("dead_abort_cnt", 32'(sw_cnt), 4);

        // asynchronous reset while the top gate is on
        enable = 1'b1; pwm = 1'b1; dt_cfg = 1;
        n = 0;
        while (!top_en && n < 20) begin tick(); n++; end
        chk("pre_rst_top", 32'(top_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_top", 32'(top_en), 0);
        chk("rst_async_cnt", 32'(sw_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 500 toggles to wrap the 8-bit switching counter
        n = 0;
        while (!top_en && n < 20) begin tick(); n++; end
        chk("wrap_first_top", 32'(top_en), 1);
        exp_cnt = 1;
        saw_wrap = 1'b0;
        prev_cnt = sw_cnt;
        for (int i = 0; i < 500; i++) begin
            pwm = ~pwm;
            n = 0;
            tgt = 1'b0;
            while (!tgt && n < 20) begin
                tick();
                n++;
                if (prev_cnt == '1 && sw_cnt == '0) saw_wrap = 1'b1;
                prev_cnt = sw_cnt;
                tgt = pwm ? top_en : bot_en;
            end
            chk($sformatf("wrap_toggle%0d", i), 32'(tgt), 1);
            exp_cnt++;
        end
        chk("wrap_cnt", 32'(sw_cnt), 32'(exp_cnt % 256));
        chk("wrap_seen", 32'(saw_wrap), 1);
        chk("wrap_no_fault", 32'(fault), 0);

        // randomized run, checked cycle by cycle against the model
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 19) == 0) pwm = ~pwm;
            if ($urandom_range(0, 29) == 0) dt_cfg = DT_W'($urandom_range(0, 9));
            fault_clr = ($urandom_range(0, 29) == 0);
            if (stuck == 0 && $urandom_range(0, 199) == 0) stuck = 80;
            top_fb = top_en || (stuck > 0);
            bot_fb = bot_en;
            if ($urandom_range(0, 99) == 0) begin top_fb = 1'b1; bot_fb = 1'b1; end
            if (stuck > 0) stuck--;
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/loop_deadtime_ctrl.md
# loop_deadtime_ctrl

Break-before-make controller for the loop driver's top/bottom gate pair. It turns the single `pwm` request into non-overlapping `top_en` / `bot_en` enables for the driver gate cells. It closes the loop on the sensed gate states `top_fb` / `bot_fb` that the driver returns. It sits between the loop PWM generator and the top/bottom driver stages, and latches a fault on a gate-off timeout or on shoot-through.

## Interface
- `DT_W`, 6: width of the dead-time configuration.
- `TMO`, 64: maximum cycles allowed in `WAIT_OFF` before a timeout fault.
- `CNT_W`, 16: width of the switching-event counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run request; 0 forces both enables off.
- `pwm` in 1: 1 requests top on, 0 requests bottom on.
- `dt_cfg` in `DT_W`: dead time in cycles; 0 is treated as 1.
- `top_fb` in 1: sensed top gate high, asynchronous.
- `bot_fb` in 1: sensed bottom gate high, asynchronous.
- `fault_clr` in 1: single-cycle pulse that clears a latched fault.
- `top_en` out 1: top gate drive enable, registered.
- `bot_en` out 1: bottom gate drive enable, registered.
- `fault` out 1: fault latched.
- `fault_code` out 2: 00 none, 01 timeout, 10 shoot-through.
- `sw_cnt` out `CNT_W`: count of completed `TOP_ON`/`BOT_ON` entries; wraps.

## Operation
- `top_fb` and `bot_fb` pass through 2-flop synchronizers, giving `top_fb_s` and `bot_fb_s`. All decisions use the synchronized values.
- States: `OFF`, `WAIT_OFF`, `DEAD`, `TOP_ON`, `BOT_ON`, `FAULT`.
- Outputs are Moore and registered:
  - `top_en` = 1 only in `TOP_ON`.
  - `bot_en` = 1 only in `BOT_ON`.
  - `fault` = 1 only in `FAULT`.
- Transitions, in priority order:
  1. `top_fb_s` & `bot_fb_s` in any non-`FAULT` state → `FAULT`, code 10.
  2. `enable` = 0 in any non-`FAULT` state → `OFF`.
  3. Per-state rules:
     - `OFF`: `enable` = 1 → `WAIT_OFF`, timeout counter cleared.
     - `WAIT_OFF`: both synced feedbacks 0 → `DEAD`, dead counter loaded with max(`dt_cfg`, 1). Otherwise the timeout counter increments; reaching `TMO` → `FAULT`, code 01.
     - `DEAD`: the counter decrements. On the cycle it reaches 1, go to `TOP_ON` if `pwm` = 1, else `BOT_ON`, and increment `sw_cnt`. `pwm` changes during `DEAD` are honoured at exit only.
     - `TOP_ON`: `pwm` = 0 → `WAIT_OFF`.
     - `BOT_ON`: `pwm` = 1 → `WAIT_OFF`.
     - `FAULT`: `fault_clr` = 1 → `OFF`, `fault_code` cleared. `enable` is ignored in this state.
- `dt_cfg` is sampled only when `DEAD` is entered; mid-count changes have no effect.
- `sw_cnt` wraps from all-ones to 0 and is not cleared by a fault.
- Reset values:
  - State `OFF`.
  - `top_en` = `bot_en` = 0.
  - `fault` = 0, `fault_code` = 00.
  - `sw_cnt` = 0.
  - Synchronizers and counters 0.
- Reset asserted mid-operation drops both enables asynchronously in the same instant.

## Timing
- Feedback latency is 2 cycles from pin to `*_fb_s`.
- The enable being switched off drops 1 cycle after the `pwm` edge is sampled.
- The opposite enable rises no earlier than: 1 cycle (`WAIT_OFF` exit) + 2-cycle sync + max(`dt_cfg`, 1) cycles after the feedback pin falls.
- With instant feedback, `pwm` toggle to opposite enable takes 1 + 2 + 1 + max(`dt_cfg`, 1) cycles.
- A timeout fault asserts `fault` `TMO` + 1 cycles after entering `WAIT_OFF` if a feedback stays high.
- A shoot-through fault asserts 1 cycle after both synced feedbacks are high; the enables are 0 that same cycle.
- If `fault_clr` and a shoot-through condition coincide in `FAULT`, the block stays in `FAULT`.

## Structure
- Package `loop_drv_pkg`: state enum `loop_dt_state_t`, and fault-code constants `FC_NONE`, `FC_TMO`, `FC_SHOOT`.
- Sub-module `loop_fb_sync`: a 2-flop synchronizer with async active-high reset to 0, instantiated twice.
- The FSM, counters and output registers live in `loop_deadtime_ctrl`.

## Test plan
- Reset, then `enable` = 1, `pwm` = 0, feedbacks 0, `dt_cfg` = 4 → `bot_en` rises 5 cycles after `WAIT_OFF` is entered; `top_en` stays 0; `sw_cnt` = 1.
- In `BOT_ON`, raise `pwm`; `bot_fb` falls 3 cycles later; `dt_cfg` = 0 → `bot_en` drops at +1 cycle. `top_en` rises exactly 1 (exit) + 2 (sync) + 1 (dead) cycles after the `bot_fb` fall, and never overlaps `bot_en`.
- Hold `top_fb` = 1 after `pwm` falls → `fault` = 1 with `fault_code` = 01 after 65 cycles in `WAIT_OFF`. A `fault_clr` pulse returns the block to `OFF`, then `WAIT_OFF` if `enable` = 1.
- Drive `top_fb` = `bot_fb` = 1 while in `TOP_ON` → `fault_code` = 10 and both enables 0 within 3 cycles. `enable` toggling has no effect until `fault_clr`.
- Drop `enable` mid-`DEAD` → `OFF` next cycle, no `sw_cnt` increment. Assert `rst` during `TOP_ON` → `top_en` = 0 immediately.
- Preload 500 toggles with `CNT_W` = 8 → `sw_cnt` wraps from 255 to 0 with no other side effects.
